// File: rtl/core_bus_pkg.sv
// Shared types for the cache-line bus arbiter: bus request/response structs,
// arbiter FSM states and arbitration-mode constants.
package core_bus_pkg;

   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   typedef struct packed {
      logic        valid;
      logic        write;
      logic [3:0]  burst_size;
      logic        cached;
      logic [1:0]  data_size;
      logic [31:0] addr;
      logic        data_ok;
      logic        data_last;
      logic [3:0]  data_strobe;
      logic [31:0] w_data;
   } cache_bus_req_t;

   typedef struct packed {
      logic        ready;
      logic        data_ok;
      logic        data_last;
      logic [31:0] r_data;
   } cache_bus_resp_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } bus_arb_state_t;

   // Wrap-around successor of a requester index.
   function automatic int next_index(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/core_bus_arbiter_if.sv
// Bundle of the arbiter's master-side and downstream-side bus signals.
interface core_bus_arbiter_if #(parameter int N_MASTER = 2);
   import core_bus_pkg::*;

   localparam int OW = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;

   cache_bus_req_t  [N_MASTER-1:0] m_req_i;
   cache_bus_resp_t [N_MASTER-1:0] m_resp_o;
   logic            [N_MASTER-1:0] m_busy_o;
   cache_bus_req_t                 s_req_o;
   cache_bus_resp_t                s_resp_i;
   logic            [OW-1:0]       owner_o;
   logic                           err_o;

   // Arbiter side.
   modport slave (
      input  m_req_i, s_resp_i,
      output m_resp_o, m_busy_o, s_req_o, owner_o, err_o
   );

   // Environment side: the caches plus the downstream port.
   modport master (
      output m_req_i, s_resp_i,
      input  m_resp_o, m_busy_o, s_req_o, owner_o, err_o
   );

endinterface

// File: rtl/core_rr_picker.sv
// N-way one-hot request picker: round-robin starting at ptr when rr_en is set,
// otherwise fixed priority with the lowest index winning.
module core_rr_picker #(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   input  logic          rr_en,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          any
);

   int            base_s;
   logic [IW-1:0] idx_s;
   logic          hit_s;

   // Scan from the base index and keep the first requester found.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      idx_s     = '0;
      hit_s     = 1'b0;
      base_s    = rr_en ? int'(ptr) : 0;
      for (int k = 0; k < N; k++) begin
         idx_s        = IW'((base_s + k) % N);
         hit_s        = !any && req[idx_s];
         grant[idx_s] = grant[idx_s] | hit_s;
         grant_idx    = hit_s ? idx_s : grant_idx;
         any          = any | hit_s;
      end
   end

endmodule

// File: rtl/core_bus_arbiter.sv
// Shares one cache-line bus port between icache (0) and dcache (1); the grant
// is held from address phase through the last data beat.
module core_bus_arbiter
   import core_bus_pkg::*;
#(
   parameter int N_MASTER  = 2,
   parameter int ARB_MODE  = 1,
   parameter int MAX_BEATS = 16
) (
   input  logic               clk,
   input  logic               rst,
   core_bus_arbiter_if.slave  bus
);

   localparam int            OW         = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;
   localparam int            BW         = $clog2(MAX_BEATS + 1);
   localparam logic [BW-1:0] BEAT_LIMIT = BW'(MAX_BEATS);

   bus_arb_state_t      state_r;
   logic [OW-1:0]       owner_r;
   logic [OW-1:0]       rr_ptr_r;
   logic [BW-1:0]       beat_r;
   logic                err_r;
   logic [N_MASTER-1:0] busy_r;

   logic [N_MASTER-1:0] req_valid_s;
   logic [N_MASTER-1:0] win_oh_s;
   logic [OW-1:0]       win_idx_s;
   logic                any_req_s;
   logic [N_MASTER-1:0] sel_oh_s;

   // Collect the valid bits for the picker.
   always_comb begin
      req_valid_s = '0;
      for (int i = 0; i < N_MASTER; i++) begin
         req_valid_s[i] = bus.m_req_i[i].valid;
      end
   end

   core_rr_picker #(.N(N_MASTER), .IW(OW)) u_picker (
      .req       (req_valid_s),
      .ptr       (rr_ptr_r),
      .rr_en     (ARB_MODE == ARB_RR),
      .grant     (win_oh_s),
      .grant_idx (win_idx_s),
      .any       (any_req_s)
   );

   // Downstream request mux; the IDLE winner is forwarded in its grant cycle.
   always_comb begin
      bus.s_req_o = '0;
      sel_oh_s    = '0;
      if (rst) begin
         bus.s_req_o = '0;
         sel_oh_s    = '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (any_req_s) begin
                  bus.s_req_o = bus.m_req_i[win_idx_s];
                  sel_oh_s    = win_oh_s;
               end else begin
                  bus.s_req_o = '0;
               end
            end
            ST_ADDR: begin
               bus.s_req_o        = bus.m_req_i[owner_r];
               sel_oh_s[owner_r]  = 1'b1;
            end
            ST_DATA: begin
               bus.s_req_o        = bus.m_req_i[owner_r];
               bus.s_req_o.valid  = 1'b0;
               sel_oh_s[owner_r]  = 1'b1;
            end
            default: begin
               bus.s_req_o = '0;
               sel_oh_s    = '0;
            end
         endcase
      end
   end

   // Only the selected master ever sees the downstream response.
   always_comb begin
      for (int i = 0; i < N_MASTER; i++) begin
         bus.m_resp_o[i] = sel_oh_s[i] ? bus.s_resp_i : '0;
      end
   end

   // Arbiter FSM with owner, round-robin pointer, beat count and busy flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= ST_IDLE;
         owner_r  <= '0;
         rr_ptr_r <= '0;
         beat_r   <= '0;
         err_r    <= 1'b0;
         busy_r   <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (any_req_s) begin
                  owner_r <= win_idx_s;
                  state_r <= bus.s_resp_i.ready ? ST_DATA : ST_ADDR;
                  busy_r  <= ~win_oh_s;
               end else begin
                  busy_r  <= '0;
               end
            end
            ST_ADDR: begin
               state_r <= bus.s_resp_i.ready ? ST_DATA : ST_ADDR;
            end
            ST_DATA: begin
               if (bus.s_resp_i.data_ok && bus.s_resp_i.data_last) begin
                  state_r  <= ST_IDLE;
                  busy_r   <= '0;
                  beat_r   <= '0;
                  rr_ptr_r <= OW'(next_index(int'(owner_r), N_MASTER));
               end else if (bus.s_resp_i.data_ok) begin
                  // Overflow is flagged but the transfer keeps running.
                  beat_r <= (beat_r == BEAT_LIMIT) ? beat_r : beat_r + BW'(1);
                  err_r  <= err_r | (beat_r >= BEAT_LIMIT - BW'(1));
               end else begin
                  state_r <= ST_DATA;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= '0;
            end
         endcase
      end
   end

   assign bus.m_busy_o = busy_r;
   assign bus.owner_o  = owner_r;
   assign bus.err_o    = err_r;

endmodule
